excp_ctrl: RTL
==============

# excp_ctrl

Trap sequencer between the pipeline (IDU/EXU) and `csrfile`. It accepts ecall, mret and (optionally) machine-timer interrupt events, and drives the `csrfile` mepc/mcause/mstatus write ports from a small FSM. It then issues a single-cycle PC redirect to `mtvec` or `mepc`, and holds the pipeline busy for the whole sequence.

## Interface
Parameters:
- `MTIMECMP_RST`, default `32'hFFFF_FFFF`: reset value of the internal mtimecmp.

Ports:
- `i_clk`  in  1  clock. The block has one clock; reset is synchronous and active-low (`i_rst_n`).
- `i_rst_n`  in  1  synchronous active-low reset.
- `i_valid`  in  1  instruction at `i_pc` is presented this cycle.
- `i_pc`  in  `CPU_WIDTH`  PC of the presented instruction.
- `i_ecall`  in  1  presented instruction is ecall (qualified by `i_valid`).
- `i_mret`  in  1  presented instruction is mret (qualified by `i_valid`).
- `i_mstatus`, `i_mtvec`, `i_mepc`  in  `CPU_WIDTH` each  from `csrfile` `o_mstatus`/`o_mtvec`/`o_mepc`.
- `o_mepc_wen`/`o_mepc_wdata`, `o_mcause_wen`/`o_mcause_wdata`, `o_mstatus_wen`/`o_mstatus_wdata`  out  1/`CPU_WIDTH`  to `csrfile` excp/intr ports.
- `o_busy`  out  1  sequence in progress; upstream stalls and squashes the presented instruction.
- `o_redirect`  out  1  one-cycle PC redirect strobe.
- `o_redirect_pc`  out  `CPU_WIDTH`  redirect target.
- `i_cmp_wen`  in  1  write mtimecmp.
- `i_cmp_wdata`  in  32  mtimecmp write data.
- `o_mtime`  out  32  current mtime.
- `o_tip`  out  1  timer interrupt pending.

## Operation
FSM states: IDLE, TRAP, MRET, REDIR.

Event decode in IDLE, in priority order:
- **Interrupt.** `o_tip & i_mstatus[3]` (MIE). Latch cause `32'h8000_0007` and epc `i_pc`; go to TRAP. The presented instruction is not executed, even if it is ecall or mret.
- **Ecall.** `i_valid & i_ecall`. Latch cause `32'd11` and epc `i_pc`; go to TRAP.
- **Mret.** `i_valid & i_mret`. Go to MRET.

All events are ignored outside IDLE.

TRAP state (one cycle):
- All three wen strobes are high.
- `o_mepc_wdata` = latched epc; `o_mcause_wdata` = latched cause.
- `o_mstatus_wdata` = `i_mstatus` with MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11.
- Next state REDIR, with target `{i_mtvec[31:2],2'b00}` (direct mode only).

MRET state (one cycle):
- Only `o_mstatus_wen` is high.
- `o_mstatus_wdata`: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
- Next state REDIR, with target `i_mepc`.

REDIR state (one cycle):
- `o_redirect` = 1 and `o_redirect_pc` = the latched target.
- Next state IDLE.

`o_busy` is 1 in TRAP, MRET and REDIR, and also combinationally in IDLE on the cycle an event is accepted.

Reset values: state IDLE; all wen strobes, `o_redirect`, `o_busy` (registered part), `o_tip` and `o_mtime` are 0; `o_redirect_pc` is 0; mtimecmp is `MTIMECMP_RST`.

Reset mid-sequence returns the FSM to IDLE with no further CSR writes. A partially completed sequence is not resumed.

## Timing
- Cycle 0: event accepted in IDLE.
- Cycle 1: CSR write strobes; `csrfile` updates at the end of cycle 1.
- Cycle 2: redirect.
- Latency from event to redirect is 2 cycles. The earliest next event is accepted in cycle 3.
- `o_redirect_pc` in cycle 2 reflects the `i_mtvec`/`i_mepc` values sampled in cycle 1.
- Write data is combinational from the latched values and the current `i_mstatus`. No `csrfile` write to mstatus can occur concurrently, because the pipeline is stalled.

## Configuration
Macro `EXCP_TIMER_EN` adds the timer.

Defined:
- mtime is a 32-bit counter that increments every cycle and wraps from `FFFF_FFFF` to 0.
- Pending is set when mtime == mtimecmp, and cleared by `i_cmp_wen`.
- If a write and a match occur in the same cycle, the write wins (pending stays 0) and mtimecmp takes the new value.
- `o_tip` = pending.
- Pending is not cleared by taking the trap; software must rewrite mtimecmp.

Undefined:
- `o_tip` = 0 and `o_mtime` = 0.
- `i_cmp_*` are ignored.
- The ports remain present.

## Structure
- Add to `defines.vh`:
  - `MCAUSE_ECALL_M` (32'd11) and `MCAUSE_MTIMER` (32'h8000_0007).
  - `MSTATUS_MIE` (3), `MSTATUS_MPIE` (7), `MSTATUS_MPP_LO`/`_HI` (11/12).
  - The FSM state encodings.
- Registers use `stdreg`.
- The timer is the one natural sub-module, `excp_timer` (mtime, mtimecmp, pending), instantiated only under `EXCP_TIMER_EN`.

## Test plan
- **Ecall.** Ecall at pc `0x8000_0010`, mtvec `0x8000_1003`, mstatus `0x8` → cycle 1: mepc `0x8000_0010`, mcause 11, mstatus `0x1880`. Cycle 2: redirect to `0x8000_1000`. Busy for cycles 0–2.
- **Mret.** Mret with mstatus `0x1880`, mepc `0x8000_0014` → cycle 1: mstatus wen only, data `0x1888`. Cycle 2: redirect to `0x8000_0014`.
- **Timer interrupt (`EXCP_TIMER_EN`).** Write mtimecmp 20, MIE=1 → pending on the cycle mtime==20. Next IDLE cycle traps with mcause `0x8000_0007` and mepc = presented pc. Rewriting mtimecmp clears `o_tip`.
- **Interrupt priority.** Pending interrupt with MIE=1 plus ecall presented in the same cycle → interrupt wins. With MIE=0 the ecall is taken with mcause 11.
- **Boundaries.**
  - Events presented during TRAP/REDIR are ignored.
  - Reset asserted in TRAP → no redirect follows; the next cycle is IDLE.
  - mtimecmp `0xFFFF_FFFF` fires on wrap.
  - A write coinciding with a match leaves pending at 0.

Source files
------------

// File: rtl/excp_ctrl_pkg.sv
// Shared constants, FSM encodings and mstatus update helpers for the trap sequencer.
// Timer support is enabled by defining EXCP_TIMER_EN.
package excp_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [CPU_WIDTH-1:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [CPU_WIDTH-1:0] MCAUSE_MTIMER  = 32'h8000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRAP  = 2'd1;
    localparam logic [1:0] ST_MRET  = 2'd2;
    localparam logic [1:0] ST_REDIR = 2'd3;

    // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous privilege.
    function automatic logic [CPU_WIDTH-1:0] trap_mstatus(input logic [CPU_WIDTH-1:0] ms);
        logic [CPU_WIDTH-1:0] r;
        r = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [CPU_WIDTH-1:0] mret_mstatus(input logic [CPU_WIDTH-1:0] ms);
        logic [CPU_WIDTH-1:0] r;
        r = ms;
        r[MSTATUS_MIE] = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/excp_timer.sv
// Machine timer: free-running mtime, writable mtimecmp and a sticky pending flag.
// Instantiated by excp_ctrl only when EXCP_TIMER_EN is defined.
module excp_timer #(
    parameter logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmp_wen,
    input  logic [31:0] cmp_wdata,
    output logic [31:0] mtime,
    output logic        tip
);

    logic [31:0] mtimecmp;

    // A compare write takes precedence over a coincident match so software can always clear pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime    <= 32'd0;
            mtimecmp <= MTIMECMP_RST;
            tip      <= 1'b0;
        end else begin
            mtime <= mtime + 32'd1;
            if (cmp_wen) begin
                mtimecmp <= cmp_wdata;
                tip      <= 1'b0;
            end else if (mtime == mtimecmp) begin
                tip <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/excp_ctrl.sv
// Trap sequencer: turns ecall/mret/timer events into csrfile writes followed by a PC redirect.
// Define EXCP_TIMER_EN to include the machine timer; otherwise o_tip and o_mtime read 0.
module excp_ctrl
    import excp_ctrl_pkg::*;
#(
    parameter logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [CPU_WIDTH-1:0] i_pc,
    input  logic                 i_ecall,
    input  logic                 i_mret,
    input  logic [CPU_WIDTH-1:0] i_mstatus,
    input  logic [CPU_WIDTH-1:0] i_mtvec,
    input  logic [CPU_WIDTH-1:0] i_mepc,
    output logic                 o_mepc_wen,
    output logic [CPU_WIDTH-1:0] o_mepc_wdata,
    output logic                 o_mcause_wen,
    output logic [CPU_WIDTH-1:0] o_mcause_wdata,
    output logic                 o_mstatus_wen,
    output logic [CPU_WIDTH-1:0] o_mstatus_wdata,
    output logic                 o_busy,
    output logic                 o_redirect,
    output logic [CPU_WIDTH-1:0] o_redirect_pc,
    input  logic                 i_cmp_wen,
    input  logic [31:0]          i_cmp_wdata,
    output logic [31:0]          o_mtime,
    output logic                 o_tip
);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [CPU_WIDTH-1:0] cause_q;
    logic [CPU_WIDTH-1:0] epc_q;
    logic [CPU_WIDTH-1:0] target_q;
    logic                 idle;
    logic                 irq_ev;
    logic                 ecall_ev;
    logic                 mret_ev;
    logic                 accept;
    logic                 unused_in;

`ifdef EXCP_TIMER_EN
    excp_timer #(
        .MTIMECMP_RST(MTIMECMP_RST)
    ) u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .cmp_wen  (i_cmp_wen),
        .cmp_wdata(i_cmp_wdata),
        .mtime    (o_mtime),
        .tip      (o_tip)
    );
    assign unused_in = ^{i_mtvec[1:0], MTIMECMP_RST};
`else
    assign o_mtime   = 32'd0;
    assign o_tip     = 1'b0;
    assign unused_in = ^{i_mtvec[1:0], MTIMECMP_RST, i_cmp_wen, i_cmp_wdata};
`endif

    assign idle     = (state_q == ST_IDLE);
    // Interrupts are not qualified by i_valid; the presented instruction is squashed either way.
    assign irq_ev   = o_tip & i_mstatus[MSTATUS_MIE];
    assign ecall_ev = i_valid & i_ecall;
    assign mret_ev  = i_valid & i_mret;
    assign accept   = i_rst_n & idle & (irq_ev | ecall_ev | mret_ev);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (irq_ev || ecall_ev) state_d = ST_TRAP;
                else if (mret_ev)       state_d = ST_MRET;
            end
            ST_TRAP:  state_d = ST_REDIR;
            ST_MRET:  state_d = ST_REDIR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (idle && (irq_ev || ecall_ev)) begin
                cause_q <= irq_ev ? MCAUSE_MTIMER : MCAUSE_ECALL_M;
                epc_q   <= i_pc;
            end
            if (state_q == ST_TRAP) target_q <= {i_mtvec[CPU_WIDTH-1:2], 2'b00};
            if (state_q == ST_MRET) target_q <= i_mepc;
        end
    end

    // Outputs are gated by reset so a sequence interrupted by reset writes nothing more.
    assign o_mepc_wen      = i_rst_n & (state_q == ST_TRAP);
    assign o_mcause_wen    = i_rst_n & (state_q == ST_TRAP);
    assign o_mstatus_wen   = i_rst_n & ((state_q == ST_TRAP) | (state_q == ST_MRET));
    assign o_mepc_wdata    = epc_q;
    assign o_mcause_wdata  = cause_q;
    assign o_mstatus_wdata = (state_q == ST_MRET) ? mret_mstatus(i_mstatus) : trap_mstatus(i_mstatus);
    assign o_redirect      = i_rst_n & (state_q == ST_REDIR);
    assign o_redirect_pc   = target_q;
    assign o_busy          = i_rst_n & (~idle | accept);

endmodule
